sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 18 +
 rtl/sram_arb_prio.sv | 37 +++
 rtl/sram_arbiter.sv | 93 +++++++++
 tb/tb_sram_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter shared types.
// Port IDs and the return-pipeline tag record.
package sram_arbiter_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
  } tag_t;

  localparam int CNT_W = 8;

endpackage

// File: rtl/sram_arb_prio.sv
// Grant logic for sram_arbiter.
// A wins by default; B wins once it has waited STARVE_LIMIT cycles.
module sram_arb_prio #(
  parameter int STARVE_LIMIT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);
  import sram_arbiter_pkg::*;

  localparam logic [CNT_W-1:0] LIMIT =
    CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved = b_req && (starve_cnt == LIMIT);
    b_gnt   = b_req && (!a_req || starved);
    a_gnt   = a_req && !b_gnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!b_req || b_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM.
// Issue registers plus a 2-deep tag pipe routing read data.
module sram_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);
  import sram_arbiter_pkg::*;

  logic                  accept;
  port_e                 sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  tag_t                  issue_tag;
  tag_t                  tag0;
  tag_t                  tag1;

  sram_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk    (clk),
    .reset_n(reset_n),
    .a_req  (a_req),
    .b_req  (b_req),
    .a_gnt  (a_gnt),
    .b_gnt  (b_gnt)
  );

  always_comb begin
    accept            = a_gnt || b_gnt;
    sel               = b_gnt ? PORT_B : PORT_A;
    sel_we            = b_gnt ? b_we : a_we;
    sel_addr          = b_gnt ? b_addr : a_addr;
    sel_wdata         = b_gnt ? b_wdata : a_wdata;
    issue_tag.valid   = accept;
    issue_tag.port    = sel;
    issue_tag.is_read = accept && !sel_we;
  end

  // Address and data hold across idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      tag0       <= '0;
      tag1       <= '0;
    end else begin
      sram_en <= accept;
      sram_we <= accept && sel_we;
      if (accept) begin
        sram_addr  <= sel_addr;
        sram_wdata <= sel_wdata;
      end
      tag0 <= issue_tag;
      tag1 <= tag0;
    end
  end

  always_comb begin
    a_rvalid = tag1.valid && tag1.is_read
            && (tag1.port == PORT_A);
    b_rvalid = tag1.valid && tag1.is_read
            && (tag1.port == PORT_B);
    a_rdata  = sram_rdata;
    b_rdata  = sram_rdata;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter.
// Vector table plus scoreboarded hand sequences.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [7:0]  a_rdata, b_rdata;
  logic        sram_en, sram_we;
  logic [15:0] sram_addr;
  logic [7:0]  sram_wdata;
  logic [7:0]  sram_rdata = 8'h00;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  typedef struct {
    logic       port;
    logic [7:0] data;
    int         due;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic ar, aw;
    logic [15:0] aa;
    logic [7:0] ad;
    logic br, bw;
    logic [15:0] ba;
    logic [7:0] bd;
    logic eag, ebg;
  } vec_t;
  vec_t vt[7];

  logic        e_en, e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;

  sram_arbiter #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(16),
    .STARVE_LIMIT(15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we),
    .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we),
    .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata(a_rdata), .b_rdata(b_rdata),
    .sram_en(sram_en), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Registered-read SRAM model.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] = sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: issue-register and return checks every cycle.
  always @(negedge clk) begin
    logic acc, sw, ea, eb;
    logic [15:0] sa;
    logic [7:0] sd;
    sb_t s;
    if (!reset_n) begin
      sb.delete();
      e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
      chk("rst_en", sram_en, 0);
      chk("rst_we", sram_we, 0);
      chk("rst_addr", sram_addr, 0);
      chk("rst_wdata", sram_wdata, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
    end else begin
      chk("sram_en", sram_en, e_en);
      chk("sram_we", sram_we, e_we);
      chk("sram_addr", sram_addr, e_addr);
      chk("sram_wdata", sram_wdata, e_wd);
      ea = 0; eb = 0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        s = sb.pop_front();
        ea = !s.port;
        eb = s.port;
        if (s.port) chk("b_rdata", b_rdata, s.data);
        else chk("a_rdata", a_rdata, s.data);
      end
      chk("a_rvalid", a_rvalid, ea);
      chk("b_rvalid", b_rvalid, eb);
      chk("gnt_onehot", a_gnt & b_gnt, 0);
      chk("gnt_noreq", (a_gnt & !a_req) | (b_gnt & !b_req), 0);
      acc = (a_req & a_gnt) | (b_req & b_gnt);
      sw = b_gnt ? b_we : a_we;
      sa = b_gnt ? b_addr : a_addr;
      sd = b_gnt ? b_wdata : a_wdata;
      e_en = acc;
      e_we = acc & sw;
      if (acc) begin
        e_addr = sa;
        e_wd = sd;
        if (sw) begin
          ref_mem[sa] = sd;
        end else begin
          s.port = b_gnt;
          s.data = ref_mem[sa];
          s.due = cyc + 2;
          sb.push_back(s);
        end
      end
    end
  end

  task automatic drive(input logic ar, aw,
                       input logic [15:0] aa,
                       input logic [7:0] ad,
                       input logic br, bw,
                       input logic [15:0] ba,
                       input logic [7:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  task automatic idle();
    a_req = 0; a_we = 0; b_req = 0; b_we = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    vt[0] = '{0,0,16'h0000,8'h00, 0,0,16'h0000,8'h00, 0,0};
    vt[1] = '{1,0,16'h0100,8'h00, 0,0,16'h0000,8'h00, 1,0};
    vt[2] = '{0,0,16'h0000,8'h00, 1,0,16'h0200,8'h00, 0,1};
    vt[3] = '{1,1,16'h0300,8'h55, 1,0,16'h0200,8'h00, 1,0};
    vt[4] = '{1,1,16'h0301,8'h66, 1,1,16'h0302,8'h77, 1,0};
    vt[5] = '{0,0,16'h0000,8'h00, 1,1,16'h0400,8'h3C, 0,1};
    vt[6] = '{1,0,16'h0300,8'h00, 0,0,16'h0000,8'h00, 1,0};

    reset_n = 0;
    drive(0,0,0,0, 0,0,0,0);
    tick(); tick();
    reset_n = 1;
    tick();

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].ar, vt[i].aw, vt[i].aa, vt[i].ad,
            vt[i].br, vt[i].bw, vt[i].ba, vt[i].bd);
      @(negedge clk);
      chk($sformatf("vec%0d_a_gnt", i), a_gnt, vt[i].eag);
      chk($sformatf("vec%0d_b_gnt", i), b_gnt, vt[i].ebg);
      tick();
      idle();
      tick();
    end
    repeat (3) tick();

    // B write then read of the same address.
    drive(0,0,0,0, 1,1,16'h1234,8'hA5);
    @(negedge clk);
    chk("wr_b_gnt", b_gnt, 1);
    tick();
    drive(0,0,0,0, 1,0,16'h1234,8'h00);
    @(negedge clk);
    chk("rd_b_gnt", b_gnt, 1);
    tick();
    idle();
    repeat (3) tick();

    // Both held: B forced through every 16th cycle.
    drive(1,0,16'h0010,0, 1,0,16'h0020,0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      chk($sformatf("starve%0d_a", k), a_gnt, (k % 16) != 15);
      chk($sformatf("starve%0d_b", k), b_gnt, (k % 16) == 15);
      tick();
    end
    idle();
    repeat (3) tick();

    // B-only write burst.
    for (int k = 0; k < 20; k++) begin
      drive(0,0,0,0, 1,1,16'h4000 + 16'(k),8'(k + 1));
      @(negedge clk);
      chk($sformatf("burst%0d_b_gnt", k), b_gnt, 1);
      chk($sformatf("burst%0d_cnt", k),
          dut.u_prio.starve_cnt, 0);
      tick();
    end

    // Preload then alternate A/B reads.
    drive(0,0,0,0, 1,1,16'h0010,8'h11);
    tick();
    drive(0,0,0,0, 1,1,16'h0020,8'h22);
    tick();
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) drive(1,0,16'h0010,0, 0,0,0,0);
      else drive(0,0,0,0, 1,0,16'h0020,0);
      @(negedge clk);
      chk($sformatf("alt%0d_gnt", k),
          {a_gnt, b_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    idle();
    repeat (3) tick();

    // Reset while a read is in flight.
    drive(1,0,16'h0010,0, 0,0,0,0);
    @(negedge clk);
    chk("inflight_a_gnt", a_gnt, 1);
    tick();
    idle();
    reset_n = 0;
    @(negedge clk);
    chk("inflight_rst_en", sram_en, 0);
    tick();
    tick();
    reset_n = 1;
    @(negedge clk);
    chk("inflight_no_rvalid", a_rvalid, 0);
    tick();

    // First accept after reset: A priority, counter at 0.
    drive(1,0,16'h0020,0, 1,0,16'h0010,0);
    @(negedge clk);
    chk("post_rst_a_gnt", a_gnt, 1);
    chk("post_rst_b_gnt", b_gnt, 0);
    chk("post_rst_cnt", dut.u_prio.starve_cnt, 0);
    tick();
    idle();
    repeat (4) tick();
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
